// File: rtl/matrix_pkg.sv
// Shared constants, opcodes and controller state encoding for the 5x5 matrix coprocessor.
package matrix_pkg;

  localparam int unsigned MAT_N     = 5;
  localparam int unsigned MAT_ELEMS = MAT_N * MAT_N;
  localparam int unsigned ELEM_W    = 8;
  localparam int unsigned MAT_W     = MAT_ELEMS * ELEM_W;
  localparam int unsigned IDX_W     = 5;

  localparam logic [2:0] OP_ADD       = 3'd0;
  localparam logic [2:0] OP_SUB       = 3'd1;
  localparam logic [2:0] OP_MUL       = 3'd2;
  localparam logic [2:0] OP_TRANSPOSE = 3'd3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StExec,
    StStore,
    StDone,
    StErr
  } ctrl_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_TRANSPOSE;
  endfunction

endpackage

// File: rtl/matrix_op_controller_if.sv
// Host command handshake plus shared data-memory port of the matrix sequencer.
interface matrix_op_controller_if
  import matrix_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_base_a;
  logic [ADDR_W-1:0] cmd_base_b;
  logic [ADDR_W-1:0] cmd_base_r;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [ELEM_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [ELEM_W-1:0] mem_wr_data;

  modport slave (
    input  cmd_valid, cmd_op, cmd_base_a, cmd_base_b, cmd_base_r, mem_rd_data,
    output cmd_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport master (
    output cmd_valid, cmd_op, cmd_base_a, cmd_base_b, cmd_base_r, mem_rd_data,
    input  cmd_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );

endinterface

// File: rtl/matrix_addr_gen.sv
// Element counter 0..24 producing base+index addresses; shared by the load and store phases.
module matrix_addr_gen
  import matrix_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (adv) begin
      idx_q <= last ? '0 : idx_q + 1'b1;
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == IDX_W'(MAT_ELEMS - 1));
  assign addr = base + ADDR_W'(idx_q);

endmodule

// File: rtl/matrix_op_controller.sv
// Command sequencer: loads A (and B) from byte memory, runs the external ALU, stores the result.
module matrix_op_controller
  import matrix_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned EXEC_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_op_controller_if.slave  bus,
  output logic [MAT_W-1:0]       op_a,
  output logic [MAT_W-1:0]       op_b,
  output logic [1:0]             op_sel,
  input  logic [MAT_W-1:0]       alu_result,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  ctrl_state_e       state_q, state_d;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] base_a_q, base_b_q, base_r_q;
  logic              phase_b_q;
  logic [15:0]       exec_cnt_q;
  logic              rd_vld_q, rd_b_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic [MAT_W-1:0]  op_a_q, op_b_q, res_q;

  logic              accept, exec_last, ag_clr, ag_adv, ag_last, rd_en, wr_en;
  logic [IDX_W-1:0]  ag_idx;
  logic [ADDR_W-1:0] ag_base, ag_addr;

  assign accept    = (state_q == StIdle) && bus.cmd_valid && op_legal(bus.cmd_op);
  assign exec_last = (exec_cnt_q == 16'(EXEC_CYC - 1));

  always_comb begin
    state_d = state_q;
    ag_clr  = 1'b0;
    ag_adv  = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          ag_clr  = 1'b1;
          state_d = op_legal(bus.cmd_op) ? StLoad : StErr;
        end
      end
      StLoad: begin
        rd_en  = 1'b1;
        ag_adv = 1'b1;
        if (ag_last && (phase_b_q || ({1'b0, op_q} == OP_TRANSPOSE))) state_d = StDrain;
      end
      StDrain: state_d = StExec;
      StExec:  if (exec_last) state_d = StStore;
      StStore: begin
        wr_en  = 1'b1;
        ag_adv = 1'b1;
        if (ag_last) state_d = StDone;
      end
      StDone, StErr: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ag_base = base_a_q;
    if (state_q == StStore) ag_base = base_r_q;
    else if (phase_b_q)     ag_base = base_b_q;
  end

  matrix_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (ag_clr),
    .adv  (ag_adv),
    .base (ag_base),
    .idx  (ag_idx),
    .addr (ag_addr),
    .last (ag_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      base_r_q   <= '0;
      phase_b_q  <= 1'b0;
      exec_cnt_q <= '0;
      rd_vld_q   <= 1'b0;
      rd_b_q     <= 1'b0;
      rd_idx_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_q      <= '0;
    end else begin
      if (accept) begin
        op_q      <= bus.cmd_op[1:0];
        base_a_q  <= bus.cmd_base_a;
        base_b_q  <= bus.cmd_base_b;
        base_r_q  <= bus.cmd_base_r;
        phase_b_q <= 1'b0;
        if (bus.cmd_op == OP_TRANSPOSE) op_b_q <= '0;
      end else if (state_q == StLoad && ag_last && state_d == StLoad) begin
        phase_b_q <= 1'b1;
      end
      // Read data lands one cycle after the strobe, so tag it with the issuing slot.
      rd_vld_q <= rd_en;
      rd_b_q   <= phase_b_q;
      rd_idx_q <= ag_idx;
      if (rd_vld_q) begin
        if (rd_b_q) op_b_q[rd_idx_q*ELEM_W +: ELEM_W] <= bus.mem_rd_data;
        else        op_a_q[rd_idx_q*ELEM_W +: ELEM_W] <= bus.mem_rd_data;
      end
      exec_cnt_q <= (state_q == StExec) ? exec_cnt_q + 16'd1 : 16'd0;
      if (state_q == StExec && exec_last) res_q <= alu_result;
    end
  end

  assign bus.cmd_ready   = (state_q == StIdle);
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);
  assign error           = (state_q == StErr);
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_en ? ag_addr : '0;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_wr_addr = wr_en ? ag_addr : '0;
  assign bus.mem_wr_data = wr_en ? res_q[ag_idx*ELEM_W +: ELEM_W] : '0;
  assign op_a            = op_a_q;
  assign op_b            = op_b_q;
  assign op_sel          = op_q;

endmodule

// File: tb/tb_matrix_op_controller.sv
// Directed bench for matrix_op_controller: EXEC_CYC=1 instance plus an EXEC_CYC=3 instance.
module tb_matrix_op_controller;
  import matrix_pkg::*;

  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_op_controller_if #(.ADDR_W(AW)) bus1 ();
  matrix_op_controller_if #(.ADDR_W(AW)) bus3 ();

  logic [MAT_W-1:0] op_a1, op_b1, alu1, op_a3, op_b3, alu3, alu3_p1, alu3_p2;
  logic [1:0]       sel1, sel3;
  logic             busy1, done1, err1, busy3, done3, err3;

  matrix_op_controller #(.ADDR_W(AW), .EXEC_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .op_a(op_a1), .op_b(op_b1), .op_sel(sel1),
    .alu_result(alu1), .busy(busy1), .done(done1), .error(err1)
  );

  matrix_op_controller #(.ADDR_W(AW), .EXEC_CYC(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .op_a(op_a3), .op_b(op_b3), .op_sel(sel3),
    .alu_result(alu3), .busy(busy3), .done(done3), .error(err3)
  );

  function automatic logic [MAT_W-1:0] alu_model(input logic [1:0] op,
                                                 input logic [MAT_W-1:0] a,
                                                 input logic [MAT_W-1:0] b);
    logic [MAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAT_ELEMS; i++) begin
      case (op)
        2'd0: r[i*ELEM_W +: ELEM_W] = a[i*ELEM_W +: ELEM_W] + b[i*ELEM_W +: ELEM_W];
        2'd1: r[i*ELEM_W +: ELEM_W] = a[i*ELEM_W +: ELEM_W] - b[i*ELEM_W +: ELEM_W];
        2'd3: r[i*ELEM_W +: ELEM_W] = a[((i % MAT_N) * MAT_N + i / MAT_N)*ELEM_W +: ELEM_W];
        default: ;
      endcase
    end
    return r;
  endfunction

  assign alu1 = alu_model(sel1, op_a1, op_b1);

  // Slow ALU: result becomes valid only in the third exec cycle.
  always @(posedge clk) begin
    alu3_p1 <= alu_model(sel3, op_a3, op_b3);
    alu3_p2 <= alu3_p1;
  end
  assign alu3 = alu3_p2;

  logic [7:0] rmem [256];
  logic [7:0] wmem [256];
  logic [7:0] rd_log [64];

  always @(posedge clk) begin
    bus1.mem_rd_data <= rmem[bus1.mem_rd_addr];
    bus3.mem_rd_data <= rmem[bus3.mem_rd_addr];
  end

  logic       use3 = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [7:0] ba = '0, bb = '0, br = '0;

  assign bus1.cmd_valid  = cmd_valid & ~use3;
  assign bus3.cmd_valid  = cmd_valid & use3;
  assign bus1.cmd_op     = cmd_op;
  assign bus3.cmd_op     = cmd_op;
  assign bus1.cmd_base_a = ba;
  assign bus3.cmd_base_a = ba;
  assign bus1.cmd_base_b = bb;
  assign bus3.cmd_base_b = bb;
  assign bus1.cmd_base_r = br;
  assign bus3.cmd_base_r = br;

  logic       s_ready, s_busy, s_rd_en, s_wr_en, s_done, s_err;
  logic [7:0] s_rd_addr, s_wr_addr, s_wr_data;
  assign s_ready   = use3 ? bus3.cmd_ready   : bus1.cmd_ready;
  assign s_busy    = use3 ? busy3            : busy1;
  assign s_rd_en   = use3 ? bus3.mem_rd_en   : bus1.mem_rd_en;
  assign s_wr_en   = use3 ? bus3.mem_wr_en   : bus1.mem_wr_en;
  assign s_done    = use3 ? done3            : done1;
  assign s_err     = use3 ? err3             : err1;
  assign s_rd_addr = use3 ? bus3.mem_rd_addr : bus1.mem_rd_addr;
  assign s_wr_addr = use3 ? bus3.mem_wr_addr : bus1.mem_wr_addr;
  assign s_wr_data = use3 ? bus3.mem_wr_data : bus1.mem_wr_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [MAT_W-1:0] got,
                       input logic [MAT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] base, input logic [7:0] val);
    for (int i = 0; i < MAT_ELEMS; i++) rmem[8'(base + i)] = val;
  endtask

  task automatic prime(input logic [7:0] base);
    for (int i = 0; i < MAT_ELEMS; i++) wmem[8'(base + i)] = 8'hEE;
  endtask

  function automatic logic [MAT_W-1:0] gather(input logic [7:0] base);
    logic [MAT_W-1:0] r;
    for (int i = 0; i < MAT_ELEMS; i++) r[i*ELEM_W +: ELEM_W] = wmem[8'(base + i)];
    return r;
  endfunction

  function automatic logic [MAT_W-1:0] splat(input logic [7:0] v);
    logic [MAT_W-1:0] r;
    for (int i = 0; i < MAT_ELEMS; i++) r[i*ELEM_W +: ELEM_W] = v;
    return r;
  endfunction

  function automatic int bad_addrs(input logic [7:0] a, input logic [7:0] b, input int n);
    int bad;
    logic [7:0] e;
    bad = 0;
    for (int i = 0; i < n && i < 64; i++) begin
      e = (i < MAT_ELEMS) ? 8'(a + i) : 8'(b + i - MAT_ELEMS);
      if (rd_log[i] !== e) bad++;
    end
    return bad;
  endfunction

  // Offers the command at a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input bit hold);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    ba        = a;
    bb        = b;
    br        = r;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic watch(input int start, output int done_cyc, output int err_cyc,
                       output int n_rd, output int n_wr, output int overlap);
    int cyc;
    cyc = start; done_cyc = -1; err_cyc = -1; n_rd = 0; n_wr = 0; overlap = 0;
    for (int k = 0; k < 200 && done_cyc < 0 && err_cyc < 0; k++) begin
      if (s_rd_en) begin
        if (n_rd < 64) rd_log[n_rd] = s_rd_addr;
        n_rd++;
      end
      if (s_wr_en) begin
        wmem[s_wr_addr] = s_wr_data;
        n_wr++;
      end
      if (s_rd_en && s_wr_en) overlap++;
      if (s_done) done_cyc = cyc;
      if (s_err) err_cyc = cyc;
      if (done_cyc < 0 && err_cyc < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic run_bin(input string tag, input logic [2:0] op, input logic [7:0] va,
                         input logic [7:0] vb, input logic [7:0] vr, input int exp_done);
    int dc, ec, nr, nw, ov;
    fill(8'h10, va);
    fill(8'h40, vb);
    prime(8'h80);
    issue(op, 8'h10, 8'h40, 8'h80, 1'b0);
    watch(1, dc, ec, nr, nw, ov);
    check({tag, " done cycle"}, dc, exp_done);
    check({tag, " reads"}, nr, 50);
    check({tag, " writes"}, nw, 25);
    check({tag, " rd/wr overlap"}, ov, 0);
    check({tag, " read addrs"}, bad_addrs(8'h10, 8'h40, nr), 0);
    check({tag, " result"}, gather(8'h80), splat(vr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc, ec, nr, nw, ov;
    logic [MAT_W-1:0] exp_t;

    repeat (2) @(negedge clk);
    check("rst cmd_ready", s_ready, 1);
    check("rst strobes", {s_busy, s_rd_en, s_wr_en, s_done, s_err}, 0);
    check("rst operands", op_a1 | op_b1, 0);
    check("rst addr/data/op_sel", {sel1, s_rd_addr, s_wr_addr, s_wr_data}, 0);
    rst = 1'b0;

    run_bin("sub", OP_SUB, 8'd10, 8'd3, 8'h07, 78);
    check("retain op_a", op_a1, splat(8'd10));
    check("retain op_b", op_b1, splat(8'd3));
    run_bin("sub wrap", OP_SUB, 8'h00, 8'h01, 8'hFF, 78);
    run_bin("add wrap", OP_ADD, 8'hFF, 8'h02, 8'h01, 78);

    for (int j = 0; j < MAT_ELEMS; j++) rmem[8'(8'hF0 + j)] = 8'(j);
    for (int i = 0; i < MAT_ELEMS; i++) exp_t[i*ELEM_W +: ELEM_W] = 8'((i % 5) * 5 + i / 5);
    prime(8'h20);
    issue(OP_TRANSPOSE, 8'hF0, 8'h40, 8'h20, 1'b0);
    watch(1, dc, ec, nr, nw, ov);
    check("tr done cycle", dc, 53);
    check("tr reads", nr, 25);
    check("tr read addrs", bad_addrs(8'hF0, 8'h00, nr), 0);
    check("tr op_b zero", op_b1, 0);
    check("tr op_sel", sel1, 3);
    check("tr result", gather(8'h20), exp_t);

    issue(3'd5, 8'h10, 8'h40, 8'h80, 1'b0);
    watch(1, dc, ec, nr, nw, ov);
    check("illegal error cycle", ec, 1);
    check("illegal mem strobes", nr + nw, 0);
    @(negedge clk);
    check("illegal ready cycle 2", s_ready, 1);

    fill(8'h10, 8'd10);
    fill(8'h40, 8'd3);
    fill(8'h60, 8'h22);
    issue(OP_SUB, 8'h10, 8'h40, 8'h80, 1'b1);
    watch(1, dc, ec, nr, nw, ov);
    check("hold done cycle", dc, 78);
    check("hold no early accept", nr, 50);
    ba = 8'h60;
    @(negedge clk);
    check("hold ready after done", s_ready, 1);
    @(negedge clk);
    check("hold second accepted", {s_busy, s_rd_en, s_rd_addr}, {2'b11, 8'h60});
    cmd_valid = 1'b0;
    watch(1, dc, ec, nr, nw, ov);
    check("hold second done", dc, 78);
    check("hold second result", gather(8'h80), splat(8'h1F));

    fill(8'h10, 8'd10);
    fill(8'h40, 8'd3);
    issue(OP_SUB, 8'h10, 8'h40, 8'h80, 1'b0);
    repeat (62) @(negedge clk);
    check("store elem 10", {s_wr_en, s_wr_addr, s_wr_data}, {1'b1, 8'h8A, 8'h07});
    rst = 1'b1;
    #1;
    check("abort strobes", {s_busy, s_rd_en, s_wr_en, s_done, s_err}, 0);
    check("abort ready", s_ready, 1);
    check("abort outputs", {op_a1, sel1, s_wr_addr, s_wr_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_bin("after reset", OP_ADD, 8'd1, 8'd2, 8'd3, 78);

    use3 = 1'b1;
    run_bin("exec3", OP_ADD, 8'd5, 8'd6, 8'h0B, 80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matrix_op_controller.md
# matrix_op_controller

Sequencer for the 5×5 matrix coprocessor datapath.
- Accepts one command at a time: opcode plus three base addresses.
- Reads operand matrix A, and B for binary ops, element-by-element from byte-wide memory, one element per cycle.
- Presents both operands as flattened 200-bit buses to the combinational matrix ALU (add/sub/mul/transpose units), captures the 200-bit result, and writes it back element-by-element.
- Sits between the host command interface and the shared data memory.

## Interface
Parameters:
- ADDR_W, 8, memory address width; address arithmetic wraps modulo 2^ADDR_W
- EXEC_CYC, 1, cycles the ALU needs before its result is sampled (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle, command can be accepted
- cmd_op  in  3  0 ADD, 1 SUB, 2 MUL, 3 TRANSPOSE (A only), 4–7 illegal
- cmd_base_a / cmd_base_b / cmd_base_r  in  ADDR_W each  base addresses of A, B, result
- mem_rd_en  out  1  read strobe; data returns next cycle
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  8  read data, valid the cycle after mem_rd_en
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  8  write data
- op_a, op_b  out  200  operands to ALU; element i at bits [i*8 +: 8], i = row*5+col
- op_sel  out  2  latched opcode to ALU result mux
- alu_result  in  200  ALU result, same packing
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at command completion
- error  out  1  one-cycle pulse on illegal opcode

## Operation
- States: IDLE → LOAD → DRAIN → EXEC → STORE → DONE → IDLE; IDLE → ERR → IDLE.
- IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready. Latch op and bases, clear element counter.
- cmd_valid while not ready is ignored. No queueing.
- Illegal opcode: go to ERR. Issue no memory access, assert error for one cycle, then return to IDLE.
- LOAD: mem_rd_en=1 every cycle.
  - Addresses base_a+0..24.
  - Binary ops continue with base_b+0..24, 50 cycles total.
  - TRANSPOSE: 25 cycles. op_b is held at 0.
- Capture: a one-cycle-delayed valid/index pair writes mem_rd_data into element slot of op_a or op_b.
- DRAIN: 1 cycle; last read data captured.
- EXEC: EXEC_CYC cycles, op_a/op_b stable. alu_result registered at end of last EXEC cycle.
- STORE: 25 cycles. mem_wr_en=1, mem_wr_addr=base_r+i, mem_wr_data=result[i*8 +: 8], i=0..24.
- DONE: done=1 for one cycle, then IDLE.
- Reads and writes are never active in the same cycle.
- Controller performs no arithmetic on data. Per-element wrap-around is the ALU's; base+i wraps modulo 2^ADDR_W.
- op_a/op_b retain last loaded values after DONE until the next load overwrites them.

## Timing
- Acceptance edge = cycle 0. First mem_rd_en in cycle 1.
- done cycle = L + 1 + EXEC_CYC + 25 + 1, where L = 50 (binary ops) or 25 (TRANSPOSE).
  - Default EXEC_CYC: 78 (binary), 53 (TRANSPOSE).
  - cmd_ready high the cycle after done.
- Illegal op: error in cycle 1, cmd_ready in cycle 2.
- Reset values:
  - cmd_ready=1; every other output 0, including op_a, op_b, op_sel, addresses and wr_data.
  - State IDLE, counters 0.
- Reset mid-command aborts immediately. No further memory strobes. Partially written result is not rolled back.

## Structure
- Shared package matrix_pkg holds:
  - MAT_N=5, MAT_ELEMS=25, ELEM_W=8, MAT_W=200
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_TRANSPOSE
  - controller state enum
- One sub-module, matrix_addr_gen: element counter 0..24 with base+index address output and last-element flag, reused for LOAD and STORE.

## Test plan
- SUB, A elements all 10, B all 3, ALU model = per-element subtract → 25 writes of 0x07 at base_r..base_r+24, done at cycle 78.
- SUB, A=0x00, B=0x01 everywhere → writes 0xFF (8-bit wrap). ADD 0xFF+0x02 → 0x01.
- TRANSPOSE, base_a=0xF0 → read addresses 0xF0..0xFF,0x00..0x08 (wrap), no B reads, done at cycle 53.
- cmd_op=5 → error pulse cycle 1, zero mem strobes, cmd_ready cycle 2. Second command with cmd_valid held high during a busy SUB → accepted the cycle after done.
- rst asserted during STORE element 10 → mem_wr_en low immediately, all outputs at reset values. Next command runs normally.
- EXEC_CYC=3 with ALU model delaying result 3 cycles → correct data written, done at cycle 80.
